alu_seq: RTL and testbench

Control sequencer that drives the shared datapath ALU and owns its operand registers. On each `start` pulse it steps the ALU through the fixed six-operation control-law calculation: Error, Intgrl, Icomp, Pcomp, Accum, Accum. It captures each ALU `dst` result into the matching register and pulses `done` when Accum holds the final saturated drive value. The ALU is purely combinational; this block supplies every ALU select and flag, and all of the ALU's register-sourced operands.

---
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencer for the shared control-law ALU: steps Error, Intgrl, Icomp, Pcomp, Accum, Accum.
// Optional macro INTGRL_DEC_EN: Intgrl is only updated on every 4th sequence.
module alu_seq #(
   parameter logic [13:0] PTERM = 14'h3680,
   parameter logic [11:0] ITERM = 12'h500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dst,
   output logic [2:0]  src1sel,
   output logic [2:0]  src0sel,
   output logic        multiply,
   output logic        sub,
   output logic        mult2,
   output logic        mult4,
   output logic        saturate,
   output logic [15:0] Accum,
   output logic [15:0] Pcomp,
   output logic [11:0] Error,
   output logic [11:0] Intgrl,
   output logic [11:0] Icomp,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_INT, S_ICMP, S_PCMP, S_ACC1, S_ACC2
   } state_e;

   state_e      state_q, state_d;
   logic        mc_q, mc_d;
   logic        done_q, done_d;
   logic [15:0] accum_q, accum_d;
   logic [15:0] pcomp_q, pcomp_d;
   logic [11:0] error_q, error_d;
   logic [11:0] intgrl_q, intgrl_d;
   logic [11:0] icomp_q, icomp_d;
   logic        intgrl_en;

   // The gains are consumed by the ALU at the top level, not here.
   logic unused_params;
   assign unused_params = ^{PTERM, ITERM};

`ifdef INTGRL_DEC_EN
   logic [1:0] dec_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dec_q <= 2'd0;
      else if (done_q)
         dec_q <= dec_q + 2'd1;
   end

   assign intgrl_en = (dec_q == 2'd3);
`else
   assign intgrl_en = 1'b1;
`endif

   // NOTE: every output and next-state value gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      mc_d     = 1'b0;
      done_d   = 1'b0;
      accum_d  = accum_q;
      pcomp_d  = pcomp_q;
      error_d  = error_q;
      intgrl_d = intgrl_q;
      icomp_d  = icomp_q;
      src1sel  = 3'b111;
      src0sel  = 3'b111;
      multiply = 1'b0;
      sub      = 1'b0;
      mult2    = 1'b0;
      mult4    = 1'b0;
      saturate = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_ERR;
         end
         S_ERR: begin
            src1sel  = 3'b100;
            src0sel  = 3'b000;
            sub      = 1'b1;
            saturate = 1'b1;
            error_d  = dst[11:0];
            state_d  = S_INT;
         end
         S_INT: begin
            src1sel  = 3'b011;
            src0sel  = 3'b001;
            saturate = 1'b1;
            if (intgrl_en) intgrl_d = dst[11:0];
            state_d  = S_ICMP;
         end
         S_ICMP: begin
            // Multiplier is a 2-cycle path: capture on the second cycle only.
            src1sel  = 3'b001;
            src0sel  = 3'b001;
            multiply = 1'b1;
            mc_d     = ~mc_q;
            if (mc_q) begin
               icomp_d = dst[11:0];
               state_d = S_PCMP;
            end
         end
         S_PCMP: begin
            src1sel  = 3'b010;
            src0sel  = 3'b100;
            multiply = 1'b1;
            mc_d     = ~mc_q;
            if (mc_q) begin
               pcomp_d = dst;
               state_d = S_ACC1;
            end
         end
         S_ACC1: begin
            src1sel = 3'b100;
            src0sel = 3'b011;
            sub     = 1'b1;
            accum_d = dst;
            state_d = S_ACC2;
         end
         S_ACC2: begin
            src1sel  = 3'b000;
            src0sel  = 3'b010;
            sub      = 1'b1;
            saturate = 1'b1;
            accum_d  = dst;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mc_q     <= 1'b0;
         done_q   <= 1'b0;
         accum_q  <= 16'h0000;
         pcomp_q  <= 16'h0000;
         error_q  <= 12'h000;
         intgrl_q <= 12'h000;
         icomp_q  <= 12'h000;
      end else begin
         state_q  <= state_d;
         mc_q     <= mc_d;
         done_q   <= done_d;
         accum_q  <= accum_d;
         pcomp_q  <= pcomp_d;
         error_q  <= error_d;
         intgrl_q <= intgrl_d;
         icomp_q  <= icomp_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign Accum  = accum_q;
   assign Pcomp  = pcomp_q;
   assign Error  = error_q;
   assign Intgrl = intgrl_q;
   assign Icomp  = icomp_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the shared ALU closing the loop.
module tb_alu_seq;

   localparam logic [13:0] PTERM = 14'h3680;
   localparam logic [11:0] ITERM = 12'h500;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [11:0] fwd;
   logic [11:0] a2d_res;
   logic [15:0] dst;
   logic [2:0]  src1sel, src0sel;
   logic        multiply, sub, mult2, mult4, saturate;
   logic [15:0] Accum, Pcomp;
   logic [11:0] Error, Intgrl, Icomp;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.PTERM(PTERM), .ITERM(ITERM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dst(dst),
      .src1sel(src1sel), .src0sel(src0sel),
      .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4), .saturate(saturate),
      .Accum(Accum), .Pcomp(Pcomp), .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp),
      .busy(busy), .done(done)
   );

   // Behavioural ALU: operand muxes, add/sub with 12-bit saturation, 15x15 signed multiply.
   logic [15:0]        src1, src0_pre, src0_sc, src0_op, sum, sum_sat, prod_sat;
   logic signed [29:0] prod;
   always_comb begin
      case (src1sel)
         3'b000:  src1 = Accum;
         3'b001:  src1 = {4'h0, ITERM};
         3'b010:  src1 = {{4{Error[11]}}, Error};
         3'b011:  src1 = {{8{Error[11]}}, Error[11:4]};
         3'b100:  src1 = {4'h0, fwd};
         default: src1 = 16'h0000;
      endcase
      case (src0sel)
         3'b000:  src0_pre = {4'h0, a2d_res};
         3'b001:  src0_pre = {{4{Intgrl[11]}}, Intgrl};
         3'b010:  src0_pre = {{4{Icomp[11]}}, Icomp};
         3'b011:  src0_pre = Pcomp;
         3'b100:  src0_pre = {2'b00, PTERM};
         default: src0_pre = 16'h0000;
      endcase
      src0_sc = mult4 ? (src0_pre << 2) : mult2 ? (src0_pre << 1) : src0_pre;
      src0_op = sub ? ~src0_sc : src0_sc;
      sum     = src1 + src0_op + {15'd0, sub};
      if (saturate && !sum[15] && (|sum[14:11]))
         sum_sat = 16'h07FF;
      else if (saturate && sum[15] && !(&sum[14:11]))
         sum_sat = 16'hF800;
      else
         sum_sat = sum;
      prod = $signed(src1[14:0]) * $signed(src0_pre[14:0]);
      if (!prod[29] && (|prod[28:26]))
         prod_sat = 16'h3FFF;
      else if (prod[29] && !(&prod[28:26]))
         prod_sat = 16'hC000;
      else
         prod_sat = prod[27:12];
      dst = multiply ? prod_sat : sum_sat;
   end

   // Expected control word {src1sel, src0sel, multiply, sub, mult2, mult4, saturate} per cycle.
   function automatic logic [10:0] exp_ctrl(input int c);
      case (c)
         1:       return {3'b100, 3'b000, 5'b01001};
         2:       return {3'b011, 3'b001, 5'b00001};
         3, 4:    return {3'b001, 3'b001, 5'b10000};
         5, 6:    return {3'b010, 3'b100, 5'b10000};
         7:       return {3'b100, 3'b011, 5'b01000};
         8:       return {3'b000, 3'b010, 5'b01001};
         default: return {3'b111, 3'b111, 5'b00000};
      endcase
   endfunction

   task automatic do_reset();
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pulse start in cycle 0, return the cycle in which done was seen (0 on timeout).
   task automatic run_seq(input logic [11:0] f, input logic [11:0] a, input bit chk_ctrl,
                          output int lat);
      logic [10:0] ctrl;
      fwd     = f;
      a2d_res = a;
      @(negedge clk);
      start = 1'b1;
      lat   = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (chk_ctrl) begin
            ctrl = {src1sel, src0sel, multiply, sub, mult2, mult4, saturate};
            checks++;
            if (ctrl !== exp_ctrl(c) || busy !== (c <= 8)) begin
               errors++;
               $display("FAIL ctrl cycle %0d: got ctrl=%b busy=%b exp ctrl=%b busy=%b",
                        c, ctrl, busy, exp_ctrl(c), (c <= 8));
            end
         end
         if (done) lat = c;
      end
   endtask

   task automatic check_latency(input string name, input int lat);
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL %s latency: got %0d exp 9 (0 = timeout)", name, lat);
      end
   endtask

   task automatic check12(input string name, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h exp %h", name, got, exp);
      end
   endtask

   task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h exp %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      check16("reset Accum", Accum, 16'h0000);
      check16("reset Pcomp", Pcomp, 16'h0000);
      check12("reset Error", Error, 12'h000);
      check12("reset Intgrl", Intgrl, 12'h000);
      check12("reset Icomp", Icomp, 12'h000);
      checks++;
      if ({busy, done, src1sel, src0sel, multiply, sub, mult2, mult4, saturate} !== 13'b0_0_111_111_00000) begin
         errors++;
         $display("FAIL reset ctrl: got busy=%b done=%b sel=%b/%b flags=%b exp 0 0 111/111 00000",
                  busy, done, src1sel, src0sel, {multiply, sub, mult2, mult4, saturate});
      end
   endtask

   task automatic test_nominal();
      int lat;
      do_reset();
      run_seq(12'h100, 12'h080, 1'b1, lat);
      check_latency("nominal", lat);
      check12("nominal Error", Error, 12'h080);
      check16("nominal Pcomp", Pcomp, 16'h01B4);
`ifdef INTGRL_DEC_EN
      check12("nominal Intgrl", Intgrl, 12'h000);
      check12("nominal Icomp", Icomp, 12'h000);
      check16("nominal Accum", Accum, 16'hFF4C);
`else
      check12("nominal Intgrl", Intgrl, 12'h008);
      check12("nominal Icomp", Icomp, 12'h002);
      check16("nominal Accum", Accum, 16'hFF4A);
`endif
   endtask

   task automatic test_saturation();
      int lat;
      do_reset();
      run_seq(12'h000, 12'hFFF, 1'b0, lat);
      check_latency("saturation", lat);
      check12("saturation Error", Error, 12'h800);
   endtask

   task automatic test_back_to_back();
      int n_done = 0;
      int d1 = 0;
      int d2 = 0;
      do_reset();
      fwd     = 12'h100;
      a2d_res = 12'h080;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         start = (c == 4 || c == 9);
         if (c == 4) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL handshake busy cycle 4: got %b exp 1", busy);
            end
         end
         if (done) begin
            n_done++;
            if (n_done == 1) d1 = c;
            else if (n_done == 2) d2 = c;
         end
      end
      start = 1'b0;
      checks++;
      if (n_done !== 2 || d1 !== 9 || d2 !== 18) begin
         errors++;
         $display("FAIL handshake done: got count=%0d cycles %0d,%0d exp count=2 cycles 9,18",
                  n_done, d1, d2);
      end
   endtask

   task automatic test_accumulation();
      int lat;
`ifdef INTGRL_DEC_EN
      logic [11:0] exp_i [4] = '{12'h000, 12'h000, 12'h000, 12'h008};
`else
      logic [11:0] exp_i [3] = '{12'h008, 12'h010, 12'h018};
`endif
      do_reset();
      foreach (exp_i[k]) begin
         run_seq(12'h100, 12'h080, 1'b0, lat);
         check_latency($sformatf("accum run %0d", k + 1), lat);
         check12($sformatf("accum run %0d Intgrl", k + 1), Intgrl, exp_i[k]);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      do_reset();
      fwd     = 12'h100;
      a2d_res = 12'h080;
      @(negedge clk);
      start = 1'b1;
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check12("midreset Error", Error, 12'h000);
      check12("midreset Intgrl", Intgrl, 12'h000);
      check16("midreset Accum", Accum, 16'h0000);
      checks++;
      if ({busy, src1sel, src0sel} !== 7'b0_111_111) begin
         errors++;
         $display("FAIL midreset ctrl: got busy=%b sel=%b/%b exp 0 111/111", busy, src1sel, src0sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_seq(12'h100, 12'h080, 1'b1, lat);
      check_latency("after midreset", lat);
      check12("after midreset Error", Error, 12'h080);
   endtask

   initial begin
      rst_n   = 1'b1;
      start   = 1'b0;
      fwd     = 12'h000;
      a2d_res = 12'h000;
      test_reset();
      test_nominal();
      test_saturation();
      test_back_to_back();
      test_accumulation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
